vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Produces the pixel/line counters, a registered visible-area flag,
// active-low sync pulses and frame/vblank start strobes for a
// 640x480@60 style raster. Everything advances only on pix_en cycles.
//
// Ports:
//   clk          pixel clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   pix_en       pixel advance enable (tie high, or a 1-in-N strobe)
//   x, y         registered horizontal / vertical position
//   video_on     high while x,y lie inside the visible area
//   hsync, vsync active-low sync, SYNC_DLY extra stages behind x/y
//   frame_start  one-cycle strobe when the outputs show x=0,y=0
//   vblank_start one-cycle strobe when the outputs show x=0,y=V_ACTIVE
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_DLY = 2      // legal 0..3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic       vblank_start
);

   // First counter value of each horizontal / vertical region.
   localparam logic [9:0] HC_FRONT = 10'(H_ACTIVE);
   localparam logic [9:0] HC_SYNC  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HC_BACK  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] HC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VC_FRONT = 10'(V_ACTIVE);
   localparam logic [9:0] VC_SYNC  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VC_BACK  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] VC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

   logic [9:0]    h_cnt_r, v_cnt_r;
   logic [9:0]    h_cur_s, v_cur_s;
   logic [9:0]    h_nxt_s, v_nxt_s;
   logic          h_wrap_s, v_step_s;
   h_state_t      h_state_r, h_state_nxt_s;
   v_state_t      v_state_r, v_state_nxt_s;
   logic [SYNC_DLY:0] hs_pipe_r, vs_pipe_r;

   // Sanitised current counters and next counter values
   always_comb begin
      h_cur_s  = h_cnt_r;
      v_cur_s  = v_cnt_r;
      h_nxt_s  = h_cnt_r;
      v_nxt_s  = v_cnt_r;
      h_wrap_s = 1'b0;
      v_step_s = 1'b0;
      // An out-of-range counter (upset) is presented and restarted as 0.
      if (h_cnt_r > HC_LAST) begin
         h_cur_s = 10'd0;
      end else begin
         h_cur_s = h_cnt_r;
      end
      if (v_cnt_r > VC_LAST) begin
         v_cur_s = 10'd0;
      end else begin
         v_cur_s = v_cnt_r;
      end
      if (pix_en) begin
         if (h_cnt_r > HC_LAST) begin
            h_nxt_s = 10'd0;
         end else if (h_cnt_r == HC_LAST) begin
            h_nxt_s  = 10'd0;
            h_wrap_s = 1'b1;
         end else begin
            h_nxt_s = h_cnt_r + 10'd1;
         end
         // A corrupted h counter is not a real line end, so y stays put.
         if (v_cnt_r > VC_LAST) begin
            v_nxt_s  = 10'd0;
            v_step_s = 1'b1;
         end else if (h_wrap_s) begin
            v_nxt_s  = (v_cnt_r == VC_LAST) ? 10'd0 : v_cnt_r + 10'd1;
            v_step_s = 1'b1;
         end else begin
            v_nxt_s = v_cnt_r;
         end
      end else begin
         h_nxt_s = h_cnt_r;
         v_nxt_s = v_cnt_r;
      end
   end

   // Horizontal and vertical region next-state logic
   always_comb begin
      h_state_nxt_s = h_state_r;
      v_state_nxt_s = v_state_r;
      if (pix_en) begin
         case (h_state_r)
            H_ACT:   h_state_nxt_s = (h_nxt_s == HC_FRONT) ? H_FRONT : H_ACT;
            H_FRONT: h_state_nxt_s = (h_nxt_s == HC_SYNC)  ? H_SYNCP : H_FRONT;
            H_SYNCP: h_state_nxt_s = (h_nxt_s == HC_BACK)  ? H_BACK  : H_SYNCP;
            H_BACK:  h_state_nxt_s = (h_nxt_s == 10'd0)    ? H_ACT   : H_BACK;
            default: h_state_nxt_s = H_ACT;
         endcase
         // Counter restart always realigns the FSM, even after an upset.
         if (h_nxt_s == 10'd0) begin
            h_state_nxt_s = H_ACT;
         end else begin
            h_state_nxt_s = h_state_nxt_s;
         end
      end else begin
         h_state_nxt_s = h_state_r;
      end
      if (v_step_s) begin
         case (v_state_r)
            V_ACT:   v_state_nxt_s = (v_nxt_s == VC_FRONT) ? V_FRONT : V_ACT;
            V_FRONT: v_state_nxt_s = (v_nxt_s == VC_SYNC)  ? V_SYNCP : V_FRONT;
            V_SYNCP: v_state_nxt_s = (v_nxt_s == VC_BACK)  ? V_BACK  : V_SYNCP;
            V_BACK:  v_state_nxt_s = (v_nxt_s == 10'd0)    ? V_ACT   : V_BACK;
            default: v_state_nxt_s = V_ACT;
         endcase
         if (v_nxt_s == 10'd0) begin
            v_state_nxt_s = V_ACT;
         end else begin
            v_state_nxt_s = v_state_nxt_s;
         end
      end else begin
         v_state_nxt_s = v_state_r;
      end
   end

   // Region FSM state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_state_r <= H_ACT;
         v_state_r <= V_ACT;
      end else begin
         h_state_r <= h_state_nxt_s;
         v_state_r <= v_state_nxt_s;
      end
   end

   // Counters and registered position/strobe outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_r      <= 10'd0;
         v_cnt_r      <= 10'd0;
         x            <= 10'd0;
         y            <= 10'd0;
         video_on     <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         h_cnt_r <= h_nxt_s;
         v_cnt_r <= v_nxt_s;
         if (pix_en) begin
            x            <= h_cur_s;
            y            <= v_cur_s;
            video_on     <= (h_cur_s < HC_FRONT) && (v_cur_s < VC_FRONT);
            frame_start  <= (h_cur_s == 10'd0) && (v_cur_s == 10'd0);
            vblank_start <= (h_cur_s == 10'd0) && (v_cur_s == VC_FRONT);
         end else begin
            // Strobes must never stretch across stalled cycles.
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
         end
      end
   end

   // Sync shaping: stage 0 lines up with x/y, later stages add delay
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs_pipe_r <= {(SYNC_DLY + 1){1'b1}};
         vs_pipe_r <= {(SYNC_DLY + 1){1'b1}};
      end else if (pix_en) begin
         hs_pipe_r[0] <= (h_state_r != H_SYNCP);
         vs_pipe_r[0] <= (v_state_r != V_SYNCP);
         for (int i = 1; i <= SYNC_DLY; i++) begin
            hs_pipe_r[i] <= hs_pipe_r[i-1];
            vs_pipe_r[i] <= vs_pipe_r[i-1];
         end
      end else begin
         hs_pipe_r <= hs_pipe_r;
         vs_pipe_r <= vs_pipe_r;
      end
   end

   assign hsync = hs_pipe_r[SYNC_DLY];
   assign vsync = vs_pipe_r[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing uses the full
// 800-pixel line; the vertical raster is shortened to 16 lines
// (10 active, 2 front, 2 sync, 2 back) so whole frames stay short.
module tb_vga_timing_gen;

   logic       clk;
   logic       reset;
   logic       pix_en;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;
   logic       vblank_start;

   int checks = 0;
   int errors = 0;
   int clk_n, fs_cnt, vb_cnt, fs_last, fs_period, hs_low, vs_low, long_pulse;
   int vb_x, vb_y;
   logic vb_vo, fs_prev, vb_prev;

   vga_timing_gen #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(10),  .V_FP(2),  .V_SYNC(2),  .V_BP(2),
      .SYNC_DLY(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pix_en       (pix_en),
      .x            (x),
      .y            (y),
      .video_on     (video_on),
      .hsync        (hsync),
      .vsync        (vsync),
      .frame_start  (frame_start),
      .vblank_start (vblank_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      fs_cnt = 0; vb_cnt = 0; hs_low = 0; vs_low = 0; long_pulse = 0;
      fs_period = 0; vb_x = -1; vb_y = -1; vb_vo = 1'b1;
   endtask

   // One clock with the given enable, then sample on the falling edge.
   task automatic step(input logic pen);
      pix_en = pen;
      @(negedge clk);
      clk_n++;
      if (frame_start === 1'b1) begin
         fs_cnt++;
         if (fs_last > 0) fs_period = clk_n - fs_last;
         fs_last = clk_n;
      end
      if (vblank_start === 1'b1) begin
         vb_cnt++; vb_x = int'(x); vb_y = int'(y); vb_vo = video_on;
      end
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if ((frame_start === 1'b1 && fs_prev === 1'b1) ||
          (vblank_start === 1'b1 && vb_prev === 1'b1)) long_pulse++;
      fs_prev = frame_start;
      vb_prev = vblank_start;
   endtask

   initial begin
      reset = 1'b0; pix_en = 1'b0;
      clk_n = 0; fs_last = 0; fs_prev = 1'b0; vb_prev = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("rst_x", 32'(x), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_video_on", 32'(video_on), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_vblank_start", 32'(vblank_start), 32'd0);
      pix_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_hold_x", 32'(x), 32'd0);

      // Release: first enabled clock shows counter 0,0.
      reset = 1'b1;
      step(1'b1);
      check("c1_x", 32'(x), 32'd0);
      check("c1_y", 32'(y), 32'd0);
      check("c1_video_on", 32'(video_on), 32'd1);
      check("c1_frame_start", 32'(frame_start), 32'd1);
      check("c1_hsync", 32'(hsync), 32'd1);
      step(1'b1);
      check("c2_x", 32'(x), 32'd1);
      check("c2_frame_start", 32'(frame_start), 32'd0);
      repeat (638) step(1'b1);
      check("x639", 32'(x), 32'd639);
      check("x639_video_on", 32'(video_on), 32'd1);
      step(1'b1);
      check("x640", 32'(x), 32'd640);
      check("x640_video_on", 32'(video_on), 32'd0);

      // hsync trails x by SYNC_DLY: first low at x=658.
      repeat (17) step(1'b1);
      check("x657", 32'(x), 32'd657);
      check("x657_hsync", 32'(hsync), 32'd1);
      step(1'b1);
      check("x658_hsync", 32'(hsync), 32'd0);
      clear_stats();
      repeat (800) step(1'b1);
      check("line_hsync_low", 32'(hs_low), 32'd96);
      check("line_x", 32'(x), 32'd658);
      check("line_y", 32'(y), 32'd1);

      // Remainder of the first frame, then the simultaneous h/v wrap.
      clear_stats();
      repeat (11341) step(1'b1);
      check("last_x", 32'(x), 32'd799);
      check("last_y", 32'(y), 32'd15);
      step(1'b1);
      check("wrap_x", 32'(x), 32'd0);
      check("wrap_y", 32'(y), 32'd0);
      check("wrap_frame_start", 32'(frame_start), 32'd1);
      check("frame_period", 32'(fs_period), 32'd12800);
      check("frame_fs_count", 32'(fs_cnt), 32'd1);
      check("frame_vb_count", 32'(vb_cnt), 32'd1);
      check("vb_x", 32'(vb_x), 32'd0);
      check("vb_y", 32'(vb_y), 32'd10);
      check("vb_video_on", 32'(vb_vo), 32'd0);
      check("frame_vsync_low", 32'(vs_low), 32'd1600);

      // Half-rate enable: everything holds on idle clocks.
      clear_stats();
      step(1'b0);
      check("stall_x", 32'(x), 32'd0);
      check("stall_frame_start", 32'(frame_start), 32'd0);
      step(1'b1);
      check("stall_adv_x", 32'(x), 32'd1);
      for (int i = 2; i < 25600; i++) step((i % 2) == 1 ? 1'b1 : 1'b0);
      check("half_x", 32'(x), 32'd0);
      check("half_y", 32'(y), 32'd0);
      check("half_frame_start", 32'(frame_start), 32'd1);
      check("half_frame_period", 32'(fs_period), 32'd25600);
      check("half_fs_count", 32'(fs_cnt), 32'd1);
      check("half_vb_count", 32'(vb_cnt), 32'd1);
      check("half_long_pulse", 32'(long_pulse), 32'd0);
      check("half_hsync_low", 32'(hs_low), 32'd3072);
      check("half_vsync_low", 32'(vs_low), 32'd3200);

      // Run to x=700,y=13 (both syncs low) and reset mid-cycle.
      repeat (11100) step(1'b1);
      check("pre_rst_x", 32'(x), 32'd700);
      check("pre_rst_y", 32'(y), 32'd13);
      check("pre_rst_hsync", 32'(hsync), 32'd0);
      check("pre_rst_vsync", 32'(vsync), 32'd0);
      #2 reset = 1'b0;
      #1;
      check("async_x", 32'(x), 32'd0);
      check("async_y", 32'(y), 32'd0);
      check("async_video_on", 32'(video_on), 32'd0);
      check("async_hsync", 32'(hsync), 32'd1);
      check("async_vsync", 32'(vsync), 32'd1);
      check("async_frame_start", 32'(frame_start), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("restart_x", 32'(x), 32'd0);
      check("restart_y", 32'(y), 32'd0);
      check("restart_video_on", 32'(video_on), 32'd1);
      check("restart_frame_start", 32'(frame_start), 32'd1);

      // Backdoor upset of the h counter.
      repeat (5) @(negedge clk);
      check("pre_bd_x", 32'(x), 32'd5);
      force dut.h_cnt_r = 10'd900;
      #1 release dut.h_cnt_r;
      @(negedge clk);
      check("bd_x", 32'(x), 32'd0);
      @(negedge clk);
      check("bd_x_restart", 32'(x), 32'd0);
      @(negedge clk);
      check("bd_x_resume1", 32'(x), 32'd1);
      @(negedge clk);
      check("bd_x_resume2", 32'(x), 32'd2);
      check("bd_video_on", 32'(video_on), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
